// File: rtl/outp_vc_alloc.sv
// Virtual-circuit allocator for one router output port: grants IDLE VCs round-robin to
// requesting input ports and tracks each VC through BUSY and DRAIN until its buffer empties.
module outp_vc_alloc #(
    parameter int NIN = 5,
    parameter int VCN = 2,
    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1,
    localparam int VW = (VCN > 1) ? $clog2(VCN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NIN-1:0]    req,
    input  logic [VCN-1:0]    tail_done,
    input  logic [VCN-1:0]    vc_empty,
    output logic [NIN-1:0]    gnt,
    output logic [VW-1:0]     gnt_vc,
    output logic [VCN-1:0]    vc_busy,
    output logic [VCN*IW-1:0] vc_owner,
    output logic              err
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDrain
    } vc_state_e;

    vc_state_e      st_q    [VCN];
    logic [IW-1:0]  owner_q [VCN];
    logic [IW-1:0]  rr_q;

    logic [NIN-1:0] owned;
    logic [NIN-1:0] elig;
    logic           found_win;
    logic           found_vc;
    logic [IW-1:0]  win;
    logic [VW-1:0]  free_vc;
    logic [IW-1:0]  rr_next;
    logic           do_alloc;

    // A port that holds any non-IDLE VC may not request another one.
    always_comb begin
        owned = '0;
        for (int n = 0; n < NIN; n++) begin
            for (int v = 0; v < VCN; v++) begin
                if (st_q[v] != StIdle && owner_q[v] == IW'(n)) begin
                    owned[n] = 1'b1;
                end
            end
        end
    end

    // gnt still holds last cycle's grant, which masks a req not yet dropped.
    assign elig = req & ~owned & ~gnt;

    always_comb begin
        found_vc = 1'b0;
        free_vc  = '0;
        for (int v = 0; v < VCN; v++) begin
            if (!found_vc && st_q[v] == StIdle) begin
                found_vc = 1'b1;
                free_vc  = VW'(v);
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        found_win = 1'b0;
        win       = '0;
        for (int k = 0; k < NIN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NIN) begin
                idx = idx - NIN;
            end
            if (!found_win && elig[idx]) begin
                found_win = 1'b1;
                win       = IW'(idx);
            end
        end
    end

    assign rr_next  = (win == IW'(NIN - 1)) ? '0 : win + IW'(1);
    assign do_alloc = found_win & found_vc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VCN; v++) begin
                st_q[v]    <= StIdle;
                owner_q[v] <= '0;
            end
            rr_q   <= '0;
            gnt    <= '0;
            gnt_vc <= '0;
            err    <= 1'b0;
        end else begin
            gnt    <= '0;
            gnt_vc <= '0;
            for (int v = 0; v < VCN; v++) begin
                unique case (st_q[v])
                    StIdle: begin
                        if (tail_done[v]) begin
                            err <= 1'b1;
                        end
                    end
                    StBusy: begin
                        if (tail_done[v]) begin
                            st_q[v] <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (tail_done[v]) begin
                            err <= 1'b1;
                        end
                        if (vc_empty[v]) begin
                            st_q[v] <= StIdle;
                        end
                    end
                    default: st_q[v] <= StIdle;
                endcase
            end
            // The allocated VC is IDLE, so the loop above never moves it this cycle.
            if (do_alloc) begin
                st_q[free_vc]    <= StBusy;
                owner_q[free_vc] <= win;
                gnt              <= NIN'(1) << win;
                gnt_vc           <= free_vc;
                rr_q             <= rr_next;
            end
        end
    end

    always_comb begin
        vc_busy  = '0;
        vc_owner = '0;
        for (int v = 0; v < VCN; v++) begin
            vc_busy[v]              = (st_q[v] != StIdle);
            vc_owner[v*IW +: IW]    = owner_q[v];
        end
    end

endmodule

// File: tb/tb_outp_vc_alloc.sv
// Bench for outp_vc_alloc: directed scenarios plus random traffic, all checked against
// a per-cycle reference model of VC ownership and round-robin arbitration.
module tb_outp_vc_alloc;
    localparam int NIN = 5;
    localparam int VCN = 2;
    localparam int IW  = 3;
    localparam int VW  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NIN-1:0]    req;
    logic [VCN-1:0]    tail_done;
    logic [VCN-1:0]    vc_empty;
    logic [NIN-1:0]    gnt;
    logic [VW-1:0]     gnt_vc;
    logic [VCN-1:0]    vc_busy;
    logic [VCN*IW-1:0] vc_owner;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Model: state 0=IDLE 1=BUSY 2=DRAIN
    int m_st  [VCN];
    int m_own [VCN];
    int m_rr, m_last, m_err, e_win, e_vc;
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    outp_vc_alloc #(.NIN(NIN), .VCN(VCN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail_done (tail_done),
        .vc_empty  (vc_empty),
        .gnt       (gnt),
        .gnt_vc    (gnt_vc),
        .vc_busy   (vc_busy),
        .vc_owner  (vc_owner),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VCN; v++) begin
            m_st[v]  = 0;
            m_own[v] = 0;
        end
        m_rr   = 0;
        m_last = -1;
        m_err  = 0;
        e_win  = -1;
        e_vc   = 0;
    endtask

    function automatic bit owns(input int n);
        for (int v = 0; v < VCN; v++) begin
            if (m_st[v] != 0 && m_own[v] == n) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int idle;
        int win;
        int nxt;
        idle = -1;
        win  = -1;
        for (int v = VCN - 1; v >= 0; v--) if (m_st[v] == 0) idle = v;
        if (idle >= 0) begin
            for (int k = 0; k < NIN; k++) begin
                int n;
                n = (m_rr + k) % NIN;
                if (win < 0 && req[n] && !owns(n) && n != m_last) win = n;
            end
        end
        for (int v = 0; v < VCN; v++) begin
            nxt = m_st[v];
            if (m_st[v] == 2 && vc_empty[v]) nxt = 0;
            if (tail_done[v]) begin
                if (m_st[v] == 1) nxt = 2;
                else m_err = 1;
            end
            m_st[v] = nxt;
        end
        if (win >= 0) begin
            m_st[idle]  = 1;
            m_own[idle] = win;
            m_rr        = (win + 1) % NIN;
            e_vc        = idle;
        end
        m_last = win;
        e_win  = win;
    endtask

    task automatic check_outputs();
        logic [NIN-1:0] eg;
        logic [VCN-1:0] eb;
        eg = '0;
        eb = '0;
        if (e_win >= 0) eg[e_win] = 1'b1;
        for (int v = 0; v < VCN; v++) eb[v] = (m_st[v] != 0);
        chk("gnt", 32'(gnt), 32'(eg));
        if (e_win >= 0) chk("gnt_vc", 32'(gnt_vc), 32'(e_vc));
        chk("vc_busy", 32'(vc_busy), 32'(eb));
        for (int v = 0; v < VCN; v++) begin
            if (m_st[v] != 0) chk("vc_owner", 32'(vc_owner[v*IW +: IW]), 32'(m_own[v]));
        end
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic cyc(input logic [NIN-1:0] r, input logic [VCN-1:0] td,
                       input logic [VCN-1:0] em);
        req       = r;
        tail_done = td;
        vc_empty  = em;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        for (int n = 0; n < NIN; n++) if (gnt[n]) order.push_back(n);
        tail_done = '0;
    endtask

    function automatic logic [VCN-1:0] busy_mask();
        logic [VCN-1:0] m;
        m = '0;
        for (int v = 0; v < VCN; v++) m[v] = (m_st[v] == 1);
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [VCN-1:0] td;
        rst       = 1'b1;
        req       = '0;
        tail_done = '0;
        vc_empty  = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_owner", 32'(vc_owner), 32'd0);
        rst = 1'b0;

        // Single request
        cyc(5'b00001, 2'b00, 2'b11);
        chk("t1_gnt", 32'(gnt), 32'h01);
        chk("t1_vc", 32'(gnt_vc), 32'd0);
        chk("t1_busy", 32'(vc_busy), 32'h1);
        chk("t1_owner", 32'(vc_owner[IW-1:0]), 32'd0);
        repeat (3) cyc(5'b00000, 2'b00, 2'b11);

        // Two VCs taken, third requester waits
        do_reset();
        cyc(5'b10110, 2'b00, 2'b11);
        chk("t2_gnt1", 32'(gnt), 32'h02);
        cyc(5'b10100, 2'b00, 2'b11);
        chk("t2_gnt2", 32'(gnt), 32'h04);
        chk("t2_vc2", 32'(gnt_vc), 32'd1);
        cyc(5'b10000, 2'b00, 2'b11);
        chk("t2_wait", 32'(gnt), 32'h00);
        chk("t2_busy", 32'(vc_busy), 32'h3);

        // Drain VC0 slowly
        cyc(5'b10000, 2'b01, 2'b00);
        repeat (2) cyc(5'b10000, 2'b00, 2'b00);
        chk("t3_drain", 32'(vc_busy), 32'h3);
        cyc(5'b10000, 2'b00, 2'b01);
        chk("t3_idle", 32'(vc_busy), 32'h2);
        chk("t3_nogrant", 32'(gnt), 32'h00);
        cyc(5'b10000, 2'b00, 2'b01);
        chk("t3_gnt4", 32'(gnt), 32'h10);
        chk("t3_vc", 32'(gnt_vc), 32'd0);

        // Release all, then fair round-robin with immediate release
        repeat (3) cyc(5'b00000, busy_mask(), 2'b11);
        order.delete();
        for (int i = 0; i < 16; i++) cyc(5'b11111, busy_mask(), 2'b11);
        for (int k = 0; k < 6; k++) begin
            chk("t4_order", (k < order.size()) ? 32'(order[k]) : 32'hffff, 32'(exp_order[k]));
        end
        repeat (4) cyc(5'b00000, busy_mask(), 2'b11);

        // Stray tail_done sets sticky err
        cyc(5'b00000, 2'b10, 2'b11);
        chk("t5_err", 32'(err), 32'd1);
        repeat (2) cyc(5'b00000, 2'b00, 2'b11);
        chk("t5_sticky", 32'(err), 32'd1);

        // Async reset mid-packet
        cyc(5'b00011, 2'b00, 2'b11);
        cyc(5'b00011, 2'b00, 2'b11);
        chk("t6_busy", 32'(vc_busy), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(vc_busy), 32'h0);
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(5'b01000, 2'b00, 2'b11);
        chk("t6_gnt", 32'(gnt), 32'h08);
        chk("t6_vc", 32'(gnt_vc), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            td = '0;
            for (int v = 0; v < VCN; v++) begin
                if (m_st[v] == 1 && $urandom_range(0, 3) == 0) td[v] = 1'b1;
                if ($urandom_range(0, 60) == 0) td[v] = 1'b1;
            end
            cyc(NIN'($urandom), td, VCN'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
